// File: rtl/payload_engine_pkg.sv
// Shared types and helpers for the payload_engine sequencer.
// Holds the controller state encoding and width helpers.
package payload_engine_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SCAN,
        DRAIN,
        SAMPLE,
        REPORT
    } pe_state_t;

    localparam logic [7:0] PAD_CHAR_DEFAULT = 8'h00;

    function automatic int len_width(input int max_len);
        return (max_len < 1) ? 1 : $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/pe_sat_counter.sv
// 32-bit saturating event counter with synchronous active-low clear.
// Holds at all-ones once reached.
module pe_sat_counter (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inc,
    output logic [31:0] count
);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 32'd1;
        end
    end

endmodule

// File: rtl/payload_engine_ctrl.sv
// Byte-stream sequencer for the payload_engine regex array.
// Optional statistics counters are enabled with PE_CTRL_STATS_EN.
module payload_engine_ctrl
    import payload_engine_pkg::*;
#(
    parameter int         NUM_ENGINES  = 32,
    parameter int         MAX_LEN      = 1518,
    parameter int         DRAIN_CYCLES = 2,
    parameter logic [7:0] PAD_CHAR     = PAD_CHAR_DEFAULT,
    localparam int        LW           = len_width(MAX_LEN)
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [7:0]             in_data,
    input  logic                   in_valid,
    input  logic                   in_sop,
    input  logic                   in_eop,
    output logic                   in_ready,
    output logic [7:0]             eng_char,
    output logic                   eng_en,
    output logic                   eng_sod,
    input  logic [NUM_ENGINES-1:0] eng_match,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [NUM_ENGINES-1:0] res_match,
    output logic [LW-1:0]          res_len,
    output logic                   res_trunc,
    output logic                   busy,
    output logic [31:0]            stat_pkts,
    output logic [31:0]            stat_alerts,
    output logic [31:0]            stat_trunc
);

    localparam int            DW       = len_width(DRAIN_CYCLES);
    localparam logic [LW-1:0] LAST     = LW'(MAX_LEN - 1);
    localparam logic [DW-1:0] DCNT_END = DW'(DRAIN_CYCLES);

    pe_state_t     state;
    pe_state_t     state_nxt;
    logic [LW-1:0] count;
    logic          trunc;
    logic [DW-1:0] drain_cnt;
    logic [7:0]    char_nxt;
    logic          en_nxt;
    logic          sod_nxt;
    logic          accept;
    logic          early_sop;
    logic          at_last;

    assign accept    = in_valid & in_ready;
    assign early_sop = in_valid & in_sop & (count != '0);
    assign at_last   = (count == LAST);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (in_valid && in_sop) begin
                    state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                state_nxt = SCAN;
            end
            SCAN: begin
                if (early_sop || (accept && (in_eop || at_last))) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_cnt == DCNT_END) begin
                    state_nxt = SAMPLE;
                end
            end
            SAMPLE: begin
                state_nxt = REPORT;
            end
            REPORT: begin
                if (res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // DRAIN holds one extra cycle so the final pad is registered
    // into the engines before SAMPLE looks at their outputs.
    always_comb begin
        in_ready  = 1'b0;
        en_nxt    = 1'b0;
        char_nxt  = eng_char;
        sod_nxt   = 1'b0;
        res_valid = (state == REPORT);
        busy      = (state != IDLE);
        if (resetn) begin
            if (state == IDLE) begin
                in_ready = !in_sop;
            end else if (state == SCAN) begin
                in_ready = !(in_sop && (count != '0));
            end
        end
        unique case (state)
            CLEAR: begin
                sod_nxt = 1'b1;
            end
            SCAN: begin
                if (in_valid && in_ready) begin
                    en_nxt   = 1'b1;
                    char_nxt = in_data;
                end
            end
            DRAIN: begin
                if (drain_cnt != DCNT_END) begin
                    en_nxt   = 1'b1;
                    char_nxt = PAD_CHAR;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            eng_char  <= '0;
            eng_en    <= 1'b0;
            eng_sod   <= 1'b1;
            count     <= '0;
            trunc     <= 1'b0;
            drain_cnt <= '0;
            res_match <= '0;
            res_len   <= '0;
            res_trunc <= 1'b0;
        end else begin
            eng_char <= char_nxt;
            eng_en   <= en_nxt;
            eng_sod  <= sod_nxt;
            unique case (state)
                CLEAR: begin
                    count <= '0;
                    trunc <= 1'b0;
                end
                SCAN: begin
                    drain_cnt <= '0;
                    if (accept) begin
                        count <= count + 1'b1;
                    end
                    if (early_sop || (accept && !in_eop && at_last)) begin
                        trunc <= 1'b1;
                    end
                end
                DRAIN: begin
                    drain_cnt <= drain_cnt + 1'b1;
                end
                SAMPLE: begin
                    res_match <= eng_match;
                    res_len   <= count;
                    res_trunc <= trunc;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef PE_CTRL_STATS_EN
    logic hs;

    assign hs = res_valid & res_ready;

    pe_sat_counter u_pkts (
        .clk    (clk),
        .resetn (resetn),
        .inc    (hs),
        .count  (stat_pkts)
    );

    pe_sat_counter u_alerts (
        .clk    (clk),
        .resetn (resetn),
        .inc    (hs & (|res_match)),
        .count  (stat_alerts)
    );

    pe_sat_counter u_trunc (
        .clk    (clk),
        .resetn (resetn),
        .inc    (hs & res_trunc),
        .count  (stat_trunc)
    );
`else
    assign stat_pkts   = '0;
    assign stat_alerts = '0;
    assign stat_trunc  = '0;
`endif

endmodule
